thread_decode_stage: RTL

Registered, parametrised instruction-decode stage for the thread pipeline. It sits between fetch and execute. It accepts one instruction word per cycle over a valid/ready handshake, splits it into control, shift, address and register fields, and presents them one cycle later in an output register with backpressure. Unlike a purely combinational decoder, it also owns a return-address (TOS) stack driven by set-TOS and pop instructions, and a halt state machine that stops intake until the thread is resumed.

---
 rtl/thread_decode_stage_pkg.sv | 62 ++++++
 rtl/thread_decode_stage_tos_stack.sv | 46 ++++
 rtl/thread_decode_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/thread_decode_stage_pkg.sv
// thread_pkg: shared definitions for the thread decode stage.
//   CLS_B2..CLS_B5 : instruction bit positions feeding the class decode
//   cls_t          : the seven class bits of an instruction
//   decoded_t      : full decoded bundle at the default field widths
//   state_t        : intake state {RUN, HALTED}
//   decode_cls()   : class-bit decode from ins[5:2]
package thread_pkg;

    localparam int CLS_B2 = 2;
    localparam int CLS_B3 = 3;
    localparam int CLS_B4 = 4;
    localparam int CLS_B5 = 5;

    localparam int P_REG_W  = 4;
    localparam int P_ADDR_W = 10;
    localparam int P_SH_W   = (P_ADDR_W - 2) / 2;

    typedef struct packed {
        logic is_simd;
        logic is_jump;
        logic pop;
        logic zcmpw;
        logic set_tos;
        logic is_halt;
        logic idf;
    } cls_t;

    // Bundle layout for the default configuration, for consumers that
    // want to carry the decode result as a single value.
    typedef struct packed {
        logic [1:0]          alusel0;
        logic [1:0]          alusel1;
        logic [2:0]          flags;
        logic                inc;
        logic                sh1dir;
        logic                sh2dir;
        logic [P_SH_W-1:0]   shamt1;
        logic [P_SH_W-1:0]   shamt2;
        cls_t                cls;
        logic [P_ADDR_W-1:0] jump_addr;
        logic [P_REG_W-1:0]  rs0;
        logic [P_REG_W-1:0]  rs1;
        logic [P_REG_W-1:0]  rd;
    } decoded_t;

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    // b[3:0] = {b5, b4, b3, b2}. pop requires ~b4 and halt requires b4,
    // so a halt word can never pop.
    function automatic cls_t decode_cls(input logic [3:0] b);
        cls_t c;
        c.is_simd = ~b[3] & ~b[2];
        c.is_jump =  b[3] & ~b[1];
        c.pop     =  b[3] &  b[1] & ~b[2];
        c.zcmpw   =  b[2] & ~b[1] & ~b[0];
        c.set_tos = ~b[3] &  b[1] &  b[0];
        c.is_halt =  b[3] &  b[2] &  b[1];
        c.idf     =  b[2] &  b[1] & ~b[0];
        return c;
    endfunction

endpackage

// File: rtl/thread_decode_stage_tos_stack.sv
// tos_stack: return-address stack without wrap-around.
//   clk, rst_n : clock, async active-low reset (clears entries and count)
//   push, din  : push din when not full; a push on a full stack is dropped
//   pop        : drop the top entry when not empty
//   dout       : current top entry, 0 when empty
//   full, empty, count : occupancy status
module tos_stack #(
    parameter  int DEPTH = 4,
    parameter  int W     = 10,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_top_ptr;

    assign w_top_ptr = r_cnt - CW'(1);
    assign full      = (r_cnt == CW'(DEPTH));
    assign empty     = (r_cnt == '0);
    assign dout      = empty ? '0 : r_mem[w_top_ptr[IW-1:0]];
    assign count     = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (push && !full) begin
            r_mem[r_cnt[IW-1:0]] <= din;
            r_cnt                <= r_cnt + CW'(1);
        end else if (pop && !empty) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/thread_decode_stage.sv
// thread_decode_stage: registered decode stage between fetch and execute.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready/in_ins : instruction handshake
//   out_valid/out_ready   : decoded bundle handshake (held under backpressure)
//   alusel*, flags, inc, sh*dir, shamt*, class bits, jump_addr, rs0/rs1/rd : bundle
//   resume                : leave HALTED
//   flush                 : drop the output bundle, block intake this cycle
//   halted, stack_depth, err_ovf, err_unf : status
module thread_decode_stage
    import thread_pkg::*;
#(
    parameter  int REG_W       = 4,
    parameter  int ADDR_W      = 10,
    parameter  int STACK_DEPTH = 4,
    localparam int INS_W       = 10 + ADDR_W + 3 * REG_W,
    localparam int SH_W        = (ADDR_W - 2) / 2,
    localparam int SD_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INS_W-1:0]  in_ins,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        alusel0,
    output logic [1:0]        alusel1,
    output logic [2:0]        flags,
    output logic              inc,
    output logic              sh1dir,
    output logic              sh2dir,
    output logic [SH_W-1:0]   shamt1,
    output logic [SH_W-1:0]   shamt2,
    output logic              is_simd,
    output logic              is_jump,
    output logic              pop,
    output logic              zcmpw,
    output logic              set_tos,
    output logic              is_halt,
    output logic              idf,
    output logic [ADDR_W-1:0] jump_addr,
    output logic [REG_W-1:0]  rs0,
    output logic [REG_W-1:0]  rs1,
    output logic [REG_W-1:0]  rd,
    input  logic              resume,
    input  logic              flush,
    output logic              halted,
    output logic [SD_W-1:0]   stack_depth,
    output logic              err_ovf,
    output logic              err_unf
);

    state_t             r_state;
    logic               r_out_valid;
    logic [1:0]         r_alusel0, r_alusel1;
    logic [2:0]         r_flags;
    logic               r_inc, r_sh1dir, r_sh2dir;
    logic [SH_W-1:0]    r_shamt1, r_shamt2;
    cls_t               r_cls;
    logic [ADDR_W-1:0]  r_jump_addr;
    logic [REG_W-1:0]   r_rs0, r_rs1, r_rd;
    logic               r_err_ovf, r_err_unf;

    logic               w_accept;
    cls_t               w_cls;
    logic [ADDR_W-1:0]  w_addr;
    logic [ADDR_W-1:0]  w_top;
    logic               w_full, w_empty, w_push, w_pop;

    assign in_ready = (r_state == RUN) & (~r_out_valid | out_ready) & ~flush;
    assign w_accept = in_valid & in_ready;
    assign w_cls    = decode_cls(in_ins[CLS_B5:CLS_B2]);
    assign w_addr   = in_ins[9+ADDR_W:10];
    assign w_push   = w_accept & w_cls.set_tos;
    assign w_pop    = w_accept & w_cls.pop;

    tos_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_addr),
        .dout  (w_top),
        .full  (w_full),
        .empty (w_empty),
        .count (stack_depth)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_out_valid <= 1'b0;
            r_alusel0   <= '0;
            r_alusel1   <= '0;
            r_flags     <= '0;
            r_inc       <= 1'b0;
            r_sh1dir    <= 1'b0;
            r_sh2dir    <= 1'b0;
            r_shamt1    <= '0;
            r_shamt2    <= '0;
            r_cls       <= '0;
            r_jump_addr <= '0;
            r_rs0       <= '0;
            r_rs1       <= '0;
            r_rd        <= '0;
            r_err_ovf   <= 1'b0;
            r_err_unf   <= 1'b0;
        end else begin
            if (flush)         r_out_valid <= 1'b0;
            else if (w_accept) r_out_valid <= 1'b1;
            else if (out_ready) r_out_valid <= 1'b0;

            if (w_accept) begin
                r_alusel0   <= in_ins[1:0];
                r_alusel1   <= in_ins[3:2];
                r_flags     <= in_ins[8:6];
                r_inc       <= in_ins[9];
                r_shamt1    <= in_ins[9+SH_W:10];
                r_sh1dir    <= in_ins[10+SH_W];
                r_shamt2    <= in_ins[10+2*SH_W:11+SH_W];
                r_sh2dir    <= in_ins[9+ADDR_W];
                r_cls       <= w_cls;
                // the stack returns 0 when empty, which is the underflow target
                r_jump_addr <= w_cls.pop ? w_top : w_addr;
                r_rs0       <= in_ins[10+ADDR_W +: REG_W];
                r_rs1       <= in_ins[10+ADDR_W+REG_W +: REG_W];
                r_rd        <= in_ins[10+ADDR_W+2*REG_W +: REG_W];
            end

            if (w_push && w_full)  r_err_ovf <= 1'b1;
            if (w_pop && w_empty)  r_err_unf <= 1'b1;

            case (r_state)
                RUN:    if (w_accept && w_cls.is_halt) r_state <= HALTED;
                HALTED: if (resume) r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign alusel0   = r_alusel0;
    assign alusel1   = r_alusel1;
    assign flags     = r_flags;
    assign inc       = r_inc;
    assign sh1dir    = r_sh1dir;
    assign sh2dir    = r_sh2dir;
    assign shamt1    = r_shamt1;
    assign shamt2    = r_shamt2;
    assign is_simd   = r_cls.is_simd;
    assign is_jump   = r_cls.is_jump;
    assign pop       = r_cls.pop;
    assign zcmpw     = r_cls.zcmpw;
    assign set_tos   = r_cls.set_tos;
    assign is_halt   = r_cls.is_halt;
    assign idf       = r_cls.idf;
    assign jump_addr = r_jump_addr;
    assign rs0       = r_rs0;
    assign rs1       = r_rs1;
    assign rd        = r_rd;
    assign halted    = (r_state == HALTED);
    assign err_ovf   = r_err_ovf;
    assign err_unf   = r_err_unf;

endmodule
